ascon_output_serializer: RTL and testbench

Downstream stage of the ASCON-128 core. Captures each 64-bit ciphertext block the core presents on its cipher_valid/cipher outputs and the 128-bit tag presented at end-of-operation. It re-emits them as a byte stream with a valid/ready handshake: all ciphertext bytes first, then the 16 tag bytes. Sits between the core and a byte-wide link such as a UART transmitter or a bus bridge.

---
 rtl/ascon_output_serializer.sv | 185 ++++++++++++++++++
 tb/tb_ascon_output_serializer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_output_serializer.sv
// rtl/ascon_output_serializer.sv - byte serializer for ASCON-128 ciphertext words and tag
//
// Purpose: buffers 64-bit ciphertext words in a small FIFO and a 128-bit tag
// in a holding register, then emits them MSB-first as a byte stream with a
// valid/ready handshake. All buffered words are emitted before the tag.
//
// Ports:
//   clock_i         single clock, rising edge
//   resetb_i        asynchronous active-low reset
//   cipher_valid_i  one-cycle strobe, cipher_i valid
//   cipher_i        64-bit ciphertext word
//   end_i           one-cycle strobe, tag_i valid
//   tag_i           128-bit authentication tag
//   byte_o          output byte
//   byte_valid_o    byte_o valid
//   byte_ready_i    sink accepts byte_o
//   last_o          high with the final tag byte
//   busy_o          data buffered or being emitted
//   overflow_o      sticky: a word or tag was dropped

module ascon_output_serializer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         cipher_valid_i,
    input  logic [63:0]  cipher_i,
    input  logic         end_i,
    input  logic [127:0] tag_i,
    output logic [7:0]   byte_o,
    output logic         byte_valid_o,
    input  logic         byte_ready_i,
    output logic         last_o,
    output logic         busy_o,
    output logic         overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CIPHER = 2'd1,
        S_TAG    = 2'd2
    } state_t;

    state_t         state_q;
    logic [63:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic [127:0]   tag_q;
    logic           tag_pending_q;
    logic [127:0]   shift_q;
    logic [3:0]     cnt_q;
    logic           overflow_q;

    logic           fifo_empty;
    logic           fifo_full;
    logic [63:0]    rd_data;
    logic           transfer;
    logic           word_done;
    logic           pop;
    logic           push;
    logic           word_drop;
    logic           tag_load;
    logic           tag_capture;
    logic           tag_drop;

    // Pointers carry an extra wrap bit: equal means empty, equal index with
    // differing wrap bit means full.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data    = fifo_mem[rd_ptr_q[AW-1:0]];

    assign byte_valid_o = (state_q != S_IDLE);
    assign byte_o       = shift_q[127:120];
    assign last_o       = (state_q == S_TAG) && (cnt_q == 4'd15);
    assign busy_o       = (state_q != S_IDLE) || !fifo_empty || tag_pending_q;
    assign overflow_o   = overflow_q;

    assign transfer  = byte_valid_o && byte_ready_i;
    assign word_done = transfer && (state_q == S_CIPHER) && (cnt_q == 4'd7);

    // A new word or the tag is loaded either from IDLE or right after the
    // last byte of a word, so consecutive words stream with no bubble.
    assign pop      = !fifo_empty && ((state_q == S_IDLE) || word_done);
    assign tag_load = fifo_empty && tag_pending_q &&
                      ((state_q == S_IDLE) || word_done);

    // A pop frees the slot the push would otherwise find full.
    assign push      = cipher_valid_i && (!fifo_full || pop);
    assign word_drop = cipher_valid_i && fifo_full && !pop;

    assign tag_capture = end_i && !tag_pending_q;
    assign tag_drop    = end_i && tag_pending_q;

    always_ff @(posedge clock_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= cipher_i;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_q         <= '0;
            tag_pending_q <= 1'b0;
            shift_q       <= '0;
            cnt_q         <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end

            if (tag_capture) begin
                tag_q         <= tag_i;
                tag_pending_q <= 1'b1;
            end else if (tag_load) begin
                tag_pending_q <= 1'b0;
            end

            if (word_drop || tag_drop) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q <= {rd_data, 64'd0};
                        cnt_q   <= 4'd0;
                        state_q <= S_CIPHER;
                    end else if (tag_load) begin
                        shift_q <= tag_q;
                        cnt_q   <= 4'd0;
                        state_q <= S_TAG;
                    end
                end
                S_CIPHER: begin
                    if (transfer) begin
                        if (cnt_q != 4'd7) begin
                            shift_q <= {shift_q[119:0], 8'd0};
                            cnt_q   <= cnt_q + 4'd1;
                        end else if (pop) begin
                            shift_q <= {rd_data, 64'd0};
                            cnt_q   <= 4'd0;
                        end else if (tag_load) begin
                            shift_q <= tag_q;
                            cnt_q   <= 4'd0;
                            state_q <= S_TAG;
                        end else begin
                            shift_q <= '0;
                            cnt_q   <= 4'd0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_TAG: begin
                    if (transfer) begin
                        if (cnt_q != 4'd15) begin
                            shift_q <= {shift_q[119:0], 8'd0};
                            cnt_q   <= cnt_q + 4'd1;
                        end else begin
                            shift_q <= '0;
                            cnt_q   <= 4'd0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    shift_q <= '0;
                    cnt_q   <= 4'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_output_serializer.sv
// tb/tb_ascon_output_serializer.sv - directed self-checking bench for ascon_output_serializer

module tb_ascon_output_serializer;

    logic         clock_i = 1'b0;
    logic         resetb_i;
    logic         cipher_valid_i;
    logic [63:0]  cipher_i;
    logic         end_i;
    logic [127:0] tag_i;
    logic [7:0]   byte_o;
    logic         byte_valid_o;
    logic         byte_ready_i;
    logic         last_o;
    logic         busy_o;
    logic         overflow_o;

    ascon_output_serializer #(.FIFO_DEPTH(4)) dut (
        .clock_i        (clock_i),
        .resetb_i       (resetb_i),
        .cipher_valid_i (cipher_valid_i),
        .cipher_i       (cipher_i),
        .end_i          (end_i),
        .tag_i          (tag_i),
        .byte_o         (byte_o),
        .byte_valid_o   (byte_valid_o),
        .byte_ready_i   (byte_ready_i),
        .last_o         (last_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         c;
        logic       l;
    } xfer_t;

    xfer_t      xq[$];
    logic [8:0] held_q = '0;
    logic       held_v = 1'b0;
    int         stall_err = 0;
    int         stall_seen = 0;

    // Transfers are recorded at the falling edge; the next rising edge commits them.
    always @(negedge clock_i) begin
        if (byte_valid_o && byte_ready_i) begin
            xq.push_back('{b: byte_o, c: cyc, l: last_o});
        end
        if (held_v && byte_valid_o) begin
            stall_seen <= stall_seen + 1;
            if ({last_o, byte_o} != held_q) stall_err <= stall_err + 1;
        end
        held_v <= byte_valid_o && !byte_ready_i;
        held_q <= {last_o, byte_o};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle_inputs();
        cipher_valid_i = 1'b0;
        cipher_i       = '0;
        end_i          = 1'b0;
        tag_i          = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        byte_ready_i = 1'b0;
        resetb_i     = 1'b0;
        repeat (2) @(posedge clock_i);
        #1;
        resetb_i = 1'b1;
        xq.delete();
    endtask

    function automatic logic [63:0] make_word(input int k);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w = {w[55:0], 8'((k + 1) * 16 + j)};
        return w;
    endfunction

    int t0;
    int s_err0;
    int s_seen0;

    initial begin
        idle_inputs();
        byte_ready_i = 1'b0;
        resetb_i     = 1'b0;
        #2;
        check_eq("reset_outputs", {byte_o, byte_valid_o, last_o, busy_o, overflow_o}, '0);
        do_reset();

        // 1: one word, then the tag five cycles later
        byte_ready_i = 1'b1;
        for (int c = 0; c < 30; c++) begin
            next_cycle();
            if (c == 0) begin
                t0 = cyc;
                check_eq("t1_busy_c0", busy_o, 1'b0);
            end
            cipher_valid_i = (c == 0);
            cipher_i       = (c == 0) ? 64'h0011223344556677 : 64'd0;
            end_i          = (c == 5);
            tag_i          = (c == 5) ? 128'h00112233445566778899AABBCCDDEEFF : 128'd0;
            if (c == 1)  check_eq("t1_valid_c1", byte_valid_o, 1'b0);
            if (c == 24) check_eq("t1_last_c24", last_o, 1'b0);
            if (c == 25) check_eq("t1_last_c25", last_o, 1'b1);
            if (c == 25) check_eq("t1_busy_c25", busy_o, 1'b1);
            if (c == 26) check_eq("t1_busy_c26", busy_o, 1'b0);
        end
        check_eq("t1_count", xq.size(), 24);
        for (int i = 0; i < 24 && i < xq.size(); i++) begin
            logic [7:0] eb;
            eb = (i < 8) ? 8'(i * 17) : 8'((i - 8) * 17);
            check_eq($sformatf("t1_byte%0d", i),
                     {xq[i].l, 16'(xq[i].c - t0), xq[i].b},
                     {(i == 23), 16'(2 + i), eb});
        end

        // 2: four words back-to-back, sink stalls every other cycle
        do_reset();
        s_err0  = stall_err;
        s_seen0 = stall_seen;
        for (int c = 0; c < 90; c++) begin
            next_cycle();
            byte_ready_i   = (c % 2 == 0);
            cipher_valid_i = (c < 4);
            cipher_i       = (c < 4) ? make_word(c) : 64'd0;
        end
        #10;
        check_eq("t2_count", xq.size(), 32);
        for (int i = 0; i < 32 && i < xq.size(); i++) begin
            check_eq($sformatf("t2_byte%0d", i), {xq[i].l, xq[i].b},
                     {1'b0, 8'((i / 8 + 1) * 16 + (i % 8))});
        end
        check_eq("t2_stall_stable", stall_err - s_err0, 0);
        check_eq("t2_stalls_seen", (stall_seen - s_seen0) > 0, 1'b1);
        check_eq("t2_overflow", overflow_o, 1'b0);
        check_eq("t2_busy_end", busy_o, 1'b0);

        // 3: overflow with the sink blocked
        do_reset();
        byte_ready_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            cipher_valid_i = (c < 6);
            cipher_i       = (c < 6) ? make_word(c) : 64'd0;
            if (c == 5) check_eq("t3_ovf_c5", overflow_o, 1'b0);
            if (c == 7) begin
                check_eq("t3_ovf_c7", overflow_o, 1'b1);
                check_eq("t3_head", {byte_valid_o, byte_o}, {1'b1, 8'h10});
                check_eq("t3_busy", busy_o, 1'b1);
                check_eq("t3_no_xfer", xq.size(), 0);
            end
        end
        byte_ready_i = 1'b1;
        for (int c = 0; c < 50; c++) next_cycle();
        check_eq("t3_count", xq.size(), 40);
        for (int i = 0; i < 40 && i < xq.size(); i++) begin
            check_eq($sformatf("t3_byte%0d", i), xq[i].b, 8'((i / 8 + 1) * 16 + (i % 8)));
        end
        check_eq("t3_ovf_sticky", overflow_o, 1'b1);
        check_eq("t3_busy_end", busy_o, 1'b0);

        // 4: word and tag in the same cycle; a second tag while the first is pending
        do_reset();
        byte_ready_i = 1'b1;
        for (int c = 0; c < 32; c++) begin
            next_cycle();
            if (c == 0) t0 = cyc;
            cipher_valid_i = (c == 0);
            cipher_i       = (c == 0) ? 64'hA0A1A2A3A4A5A6A7 : 64'd0;
            end_i          = (c == 0) || (c == 4);
            tag_i          = (c == 0) ? 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF :
                             (c == 4) ? {128{1'b1}} : 128'd0;
            if (c == 4) check_eq("t4_ovf_before", overflow_o, 1'b0);
            if (c == 6) check_eq("t4_ovf_after", overflow_o, 1'b1);
        end
        check_eq("t4_count", xq.size(), 24);
        for (int i = 0; i < 24 && i < xq.size(); i++) begin
            logic [7:0] eb;
            eb = (i < 8) ? 8'(8'hA0 + i) : 8'(8'hB0 + i - 8);
            check_eq($sformatf("t4_byte%0d", i),
                     {xq[i].l, 16'(xq[i].c - t0), xq[i].b},
                     {(i == 23), 16'(2 + i), eb});
        end
        check_eq("t4_ovf_end", overflow_o, 1'b1);

        // 5: reset in the middle of a word
        do_reset();
        byte_ready_i = 1'b1;
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            cipher_valid_i = (c == 0);
            cipher_i       = (c == 0) ? 64'h0011223344556677 : 64'd0;
        end
        check_eq("t5_pre_reset", {byte_valid_o, byte_o}, {1'b1, 8'h44});
        resetb_i = 1'b0;
        #1;
        check_eq("t5_async_clear", {byte_o, byte_valid_o, last_o, busy_o, overflow_o}, '0);
        check_eq("t5_partial_count", xq.size(), 4);
        for (int i = 0; i < 4 && i < xq.size(); i++) begin
            check_eq($sformatf("t5_partial%0d", i), xq[i].b, 8'(i * 17));
        end
        do_reset();
        byte_ready_i = 1'b1;
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            if (c == 0) t0 = cyc;
            cipher_valid_i = (c == 0);
            cipher_i       = (c == 0) ? 64'h8899AABBCCDDEEFF : 64'd0;
        end
        check_eq("t5_count", xq.size(), 8);
        for (int i = 0; i < 8 && i < xq.size(); i++) begin
            check_eq($sformatf("t5_byte%0d", i),
                     {xq[i].l, 16'(xq[i].c - t0), xq[i].b},
                     {1'b0, 16'(2 + i), 8'(8'h88 + i * 17)});
        end
        check_eq("t5_busy_end", busy_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
